// File: rtl/taxi_basex_status_pkg.sv
// Shared types and status-vector bit positions for the 1000BASE-X status monitor.
package taxi_basex_status_pkg;

    typedef enum logic [1:0] {
        DOWN = 2'd0,
        QUAL = 2'd1,
        UP   = 2'd2
    } link_state_t;

    localparam int SV_LINK     = 0;
    localparam int SV_SYNC     = 1;
    localparam int SV_RUDI_INV = 4;
    localparam int SV_DISPERR  = 5;
    localparam int SV_NIT      = 6;

endpackage

// File: rtl/taxi_sat_cnt.sv
// Saturating event counter; a clear in the same cycle as an increment drops the event.
module taxi_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    // Count register: clear beats increment, increment stops at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + W'(1'b1);
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/taxi_basex_status_mon.sv
// Per-port 1000BASE-X status monitor: link-up qualification, flap/error counters,
// sticky sync-loss flag and a registered LED/debug byte.
module taxi_basex_status_mon
    import taxi_basex_status_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int LINK_UP_CYCLES = 125000,
    parameter int STRETCH_W      = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      status_vect,
    input  logic             clr,
    output logic             link_up,
    output logic [CNT_W-1:0] link_flap_cnt,
    output logic [CNT_W-1:0] disp_err_cnt,
    output logic [CNT_W-1:0] nit_err_cnt,
    output logic [CNT_W-1:0] rudi_inv_cnt,
    output logic             sync_lost,
    output logic [7:0]       led
);

    localparam int              QC_W    = $clog2(LINK_UP_CYCLES);
    localparam logic [QC_W-1:0] QC_LAST = QC_W'(LINK_UP_CYCLES - 1);

    logic [15:0]          status_q_r;
    logic                 sync_prev_r;
    link_state_t          state_r, state_s;
    logic [QC_W-1:0]      qual_cnt_r, qual_cnt_s;
    logic                 flap_inc_s;
    logic                 good_s;
    logic                 sync_lost_r;
    logic [STRETCH_W-1:0] stretch_r;
    logic                 err_any_s;
    logic                 err_led_s;
    logic [7:0]           led_r;

    assign good_s    = status_q_r[SV_LINK] & status_q_r[SV_SYNC];
    assign err_any_s = status_q_r[SV_RUDI_INV] | status_q_r[SV_DISPERR] | status_q_r[SV_NIT];
    assign err_led_s = (stretch_r != '0);
    assign link_up   = (state_r == UP);
    assign sync_lost = sync_lost_r;
    assign led       = led_r;

    // Input stage and previous link_sync for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q_r  <= 16'h0000;
            sync_prev_r <= 1'b0;
        end else begin
            status_q_r  <= status_vect;
            sync_prev_r <= status_q_r[SV_SYNC];
        end
    end

    // Link FSM state and qualification counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= DOWN;
            qual_cnt_r <= '0;
        end else begin
            state_r    <= state_s;
            qual_cnt_r <= qual_cnt_s;
        end
    end

    // Link FSM next state; a flap is only an UP->DOWN drop
    always_comb begin
        state_s    = state_r;
        qual_cnt_s = qual_cnt_r;
        flap_inc_s = 1'b0;
        case (state_r)
            DOWN: begin
                if (good_s) begin
                    state_s    = QUAL;
                    qual_cnt_s = '0;
                end else begin
                    state_s = DOWN;
                end
            end
            QUAL: begin
                if (!good_s) begin
                    state_s = DOWN;
                end else if (qual_cnt_r == QC_LAST) begin
                    state_s = UP;
                end else begin
                    qual_cnt_s = qual_cnt_r + QC_W'(1'b1);
                end
            end
            UP: begin
                if (!good_s) begin
                    state_s    = DOWN;
                    flap_inc_s = 1'b1;
                end else begin
                    state_s = UP;
                end
            end
            default: begin
                state_s = DOWN;
            end
        endcase
    end

    // Sticky sync loss: a falling edge outranks a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_lost_r <= 1'b0;
        end else if (!status_q_r[SV_SYNC] && sync_prev_r) begin
            sync_lost_r <= 1'b1;
        end else if (clr) begin
            sync_lost_r <= 1'b0;
        end else begin
            sync_lost_r <= sync_lost_r;
        end
    end

    // Error LED stretcher: reload on any code error, then bleed down to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stretch_r <= '0;
        end else if (err_any_s) begin
            stretch_r <= '1;
        end else if (stretch_r != '0) begin
            stretch_r <= stretch_r - STRETCH_W'(1'b1);
        end else begin
            stretch_r <= stretch_r;
        end
    end

    // LED/debug byte, one cycle behind its sources
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_r <= 8'h00;
        end else begin
            led_r <= {link_flap_cnt[2:0], err_led_s, sync_lost_r,
                      status_q_r[SV_SYNC], (state_r == QUAL), link_up};
        end
    end

    taxi_sat_cnt #(.W(CNT_W)) u_flap_cnt (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(flap_inc_s), .cnt(link_flap_cnt)
    );
    taxi_sat_cnt #(.W(CNT_W)) u_disp_cnt (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(status_q_r[SV_DISPERR]), .cnt(disp_err_cnt)
    );
    taxi_sat_cnt #(.W(CNT_W)) u_nit_cnt (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(status_q_r[SV_NIT]), .cnt(nit_err_cnt)
    );
    taxi_sat_cnt #(.W(CNT_W)) u_rudi_cnt (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(status_q_r[SV_RUDI_INV]), .cnt(rudi_inv_cnt)
    );

endmodule
